// File: rtl/program_loader.sv
// Byte-serial boot loader: header word count, then MSB-first 32-bit words
// written to instruction memory; releases CPU reset after a good load.
module program_loader #(
  parameter int unsigned DEPTH     = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [4:0]  words_loaded,
  output logic        load_done,
  output logic        load_error,
  output logic        cpu_rst_n
);

  typedef enum logic [2:0] {
    S_HDR, S_BYTE, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [4:0]  word_idx_q, word_idx_d;
  logic [31:0] word_q, word_d;
  logic        rx_ready_q, rx_ready_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic [4:0]  words_loaded_q, words_loaded_d;
  logic        load_done_q, load_done_d;
  logic        load_error_q, load_error_d;
  logic        cpu_rst_n_q, cpu_rst_n_d;
  logic        accept;

  assign accept = rx_valid & rx_ready_q;

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    byte_idx_d     = byte_idx_q;
    word_idx_d     = word_idx_q;
    word_d         = word_q;
    rx_ready_d     = rx_ready_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_we_d       = 1'b0;
    words_loaded_d = words_loaded_q;
    load_done_d    = load_done_q;
    load_error_d   = load_error_q;
    cpu_rst_n_d    = cpu_rst_n_q;
    unique case (state_q)
      S_HDR: begin
        if (accept) begin
          if (rx_data == 8'd0 || 32'(rx_data) > DEPTH) begin
            state_d      = S_ERR;
            rx_ready_d   = 1'b0;
            load_error_d = 1'b1;
            cpu_rst_n_d  = 1'b0;
          end else begin
            state_d    = S_BYTE;
            n_d        = rx_data;
            byte_idx_d = 2'd0;
            word_idx_d = 5'd0;
          end
        end
      end
      S_BYTE: begin
        if (accept) begin
          word_d     = {word_q[23:0], rx_data};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d     = S_WRITE;
            rx_ready_d  = 1'b0;
            mem_we_d    = 1'b1;
            mem_addr_d  = BASE_ADDR + {11'd0, word_idx_q};
            mem_wdata_d = word_d;
          end
        end
      end
      S_WRITE: begin
        words_loaded_d = words_loaded_q + 5'd1;
        word_idx_d     = word_idx_q + 5'd1;
        if ({3'd0, words_loaded_d} == n_q) begin
          state_d     = S_DONE;
          rx_ready_d  = 1'b0;
          load_done_d = 1'b1;
          cpu_rst_n_d = 1'b1;
        end else begin
          state_d    = S_BYTE;
          rx_ready_d = 1'b1;
          byte_idx_d = 2'd0;
        end
      end
      S_DONE, S_ERR: begin
        rx_ready_d = 1'b0;
      end
      default: begin
        state_d = S_HDR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_HDR;
      n_q            <= 8'd0;
      byte_idx_q     <= 2'd0;
      word_idx_q     <= 5'd0;
      word_q         <= 32'd0;
      rx_ready_q     <= 1'b1;
      mem_addr_q     <= BASE_ADDR;
      mem_wdata_q    <= 32'd0;
      mem_we_q       <= 1'b0;
      words_loaded_q <= 5'd0;
      load_done_q    <= 1'b0;
      load_error_q   <= 1'b0;
      cpu_rst_n_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      byte_idx_q     <= byte_idx_d;
      word_idx_q     <= word_idx_d;
      word_q         <= word_d;
      rx_ready_q     <= rx_ready_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_we_q       <= mem_we_d;
      words_loaded_q <= words_loaded_d;
      load_done_q    <= load_done_d;
      load_error_q   <= load_error_d;
      cpu_rst_n_q    <= cpu_rst_n_d;
    end
  end

  assign rx_ready     = rx_ready_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_we       = mem_we_q;
  assign words_loaded = words_loaded_q;
  assign load_done    = load_done_q;
  assign load_error   = load_error_q;
  assign cpu_rst_n    = cpu_rst_n_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: header handling, word assembly,
// write timing, reset behaviour and post-load lockout.
module tb_program_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [4:0]  words_loaded;
  logic        load_done;
  logic        load_error;
  logic        cpu_rst_n;

  int vectors;
  int miscompares;
  int cyc;
  logic [47:0] wq[$];

  program_loader #(.DEPTH(16), .BASE_ADDR(16'h0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .words_loaded (words_loaded),
    .load_done    (load_done),
    .load_error   (load_error),
    .cpu_rst_n    (cpu_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Write log plus done/error exclusivity watch
  always @(negedge clk) begin
    if (mem_we) wq.push_back({mem_addr, mem_wdata});
    if (load_done && load_error) begin
      miscompares = miscompares + 1;
      $display("FAIL excl: load_done=%b load_error=%b required not both 1",
               load_done, load_error);
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    int cnt;
    rx_valid = 1'b0;
    for (int i = 0; i < gap; i++) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    cnt = 0;
    while (!rx_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (!rx_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: rx_ready=%b required 1 within 50 cycles", rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wq.delete();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({rx_ready, mem_we, mem_addr, mem_wdata, words_loaded,
         load_done, load_error, cpu_rst_n} !== {1'b1, 1'b0, 16'h0000,
         32'h0, 5'd0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: rdy=%b we=%b addr=%h wd=%h wl=%0d dn=%b er=%b crn=%b required 1 0 0000 00000000 0 0 0 0",
               rx_ready, mem_we, mem_addr, mem_wdata, words_loaded,
               load_done, load_error, cpu_rst_n);
    end
  endtask

  task automatic test_basic();
    logic [7:0] bytes [8];
    bytes = '{8'hE0, 8'h00, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    do_reset();
    send_byte(8'h02, 0);
    for (int i = 0; i < 8; i++) send_byte(bytes[i], 0);
    vectors++;
    if (mem_we !== 1'b1 || load_done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_last_we: we=%b done=%b required 1 0", mem_we, load_done);
    end
    @(negedge clk);
    vectors++;
    if ({load_done, cpu_rst_n, mem_we, words_loaded, load_error} !==
        {1'b1, 1'b1, 1'b0, 5'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_done: dn=%b crn=%b we=%b wl=%0d er=%b required 1 1 0 2 0",
               load_done, cpu_rst_n, mem_we, words_loaded, load_error);
    end
    vectors++;
    if (wq.size() != 2) begin
      miscompares++;
      $display("FAIL basic_nwrites: got %0d required 2", wq.size());
    end else begin
      vectors++;
      if (wq[0] !== {16'h0000, 32'hE0000001}) begin
        miscompares++;
        $display("FAIL basic_w0: got %h required 0000e0000001", wq[0]);
      end
      vectors++;
      if (wq[1] !== {16'h0001, 32'h12345678}) begin
        miscompares++;
        $display("FAIL basic_w1: got %h required 000112345678", wq[1]);
      end
    end
    vectors++;
    if (mem_addr !== 16'h0001 || mem_wdata !== 32'h12345678) begin
      miscompares++;
      $display("FAIL basic_hold: addr=%h wd=%h required 0001 12345678", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_after_done();
    logic [4:0] wl0;
    wl0 = words_loaded;
    wq.delete();
    rx_data  = 8'h5A;
    rx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (rx_ready !== 1'b0 || mem_we !== 1'b0 || words_loaded !== wl0 ||
          load_done !== 1'b1) begin
        miscompares++;
        $display("FAIL after_done[%0d]: rdy=%b we=%b wl=%0d dn=%b required 0 0 %0d 1",
                 i, rx_ready, mem_we, words_loaded, load_done, wl0);
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_header_err(input logic [7:0] hdr);
    do_reset();
    send_byte(hdr, 0);
    rx_data  = 8'h01;
    rx_valid = 1'b1;
    for (int i = 0; i < 6; i++) @(negedge clk);
    rx_valid = 1'b0;
    vectors++;
    if ({load_error, cpu_rst_n, rx_ready, mem_we, load_done} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0} || wq.size() != 0) begin
      miscompares++;
      $display("FAIL hdr_err_%h: er=%b crn=%b rdy=%b we=%b dn=%b writes=%0d required 1 0 0 0 0 0",
               hdr, load_error, cpu_rst_n, rx_ready, mem_we, load_done, wq.size());
    end
  endtask

  task automatic test_full_gaps();
    do_reset();
    send_byte(8'h10, 1);
    for (int w = 0; w < 16; w++)
      for (int j = 0; j < 4; j++)
        send_byte(8'(w * 4 + j), int'($urandom_range(0, 3)));
    repeat (2) @(negedge clk);
    vectors++;
    if (words_loaded !== 5'd16 || load_done !== 1'b1 || cpu_rst_n !== 1'b1) begin
      miscompares++;
      $display("FAIL full_done: wl=%0d dn=%b crn=%b required 16 1 1",
               words_loaded, load_done, cpu_rst_n);
    end
    vectors++;
    if (wq.size() != 16) begin
      miscompares++;
      $display("FAIL full_nwrites: got %0d required 16", wq.size());
    end else begin
      for (int w = 0; w < 16; w++) begin
        logic [47:0] exp;
        exp = {16'(w), 8'(w * 4), 8'(w * 4 + 1), 8'(w * 4 + 2), 8'(w * 4 + 3)};
        vectors++;
        if (wq[w] !== exp) begin
          miscompares++;
          $display("FAIL full_w%0d: got %h required %h", w, wq[w], exp);
        end
      end
    end
  endtask

  task automatic test_rst_midload();
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (wq.size() != 0 || mem_wdata !== 32'h0 || words_loaded !== 5'd0) begin
      miscompares++;
      $display("FAIL midrst_nowrite: writes=%0d wd=%h wl=%0d required 0 00000000 0",
               wq.size(), mem_wdata, words_loaded);
    end
    send_byte(8'h01, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    @(negedge clk);
    vectors++;
    if (wq.size() != 1) begin
      miscompares++;
      $display("FAIL midrst_nwrites: got %0d required 1", wq.size());
    end else begin
      vectors++;
      if (wq[0] !== {16'h0000, 32'h11223344}) begin
        miscompares++;
        $display("FAIL midrst_w0: got %h required 000011223344", wq[0]);
      end
    end
    vectors++;
    if (load_done !== 1'b1 || words_loaded !== 5'd1) begin
      miscompares++;
      $display("FAIL midrst_done: dn=%b wl=%0d required 1 1", load_done, words_loaded);
    end
  endtask

  // A header offered during reset must be dropped, so 0x00 next is a header
  task automatic test_rst_priority();
    @(negedge clk);
    rst      = 1'b1;
    rx_data  = 8'h05;
    rx_valid = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    rx_valid = 1'b0;
    wq.delete();
    send_byte(8'h00, 0);
    vectors++;
    if (load_error !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_priority: er=%b required 1", load_error);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    do_reset();
    send_byte(8'h03, 0);
    c0 = cyc;
    for (int i = 0; i < 12; i++) send_byte(8'(8'hC0 + i), 0);
    vectors++;
    if (cyc - c0 != 14) begin
      miscompares++;
      $display("FAIL b2b_cycles: got %0d required 14", cyc - c0);
    end
    @(negedge clk);
    vectors++;
    if (wq.size() != 3) begin
      miscompares++;
      $display("FAIL b2b_nwrites: got %0d required 3", wq.size());
    end else begin
      vectors++;
      if (wq[0] !== 48'h0000_C0C1C2C3 || wq[1] !== 48'h0001_C4C5C6C7 ||
          wq[2] !== 48'h0002_C8C9CACB) begin
        miscompares++;
        $display("FAIL b2b_data: got %h %h %h required 0000c0c1c2c3 0001c4c5c6c7 0002c8c9cacb",
                 wq[0], wq[1], wq[2]);
      end
    end
    vectors++;
    if (words_loaded !== 5'd3 || load_done !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_done: wl=%0d dn=%b required 3 1", words_loaded, load_done);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    rst         = 1'b1;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;
    test_reset();
    test_basic();
    test_after_done();
    test_header_err(8'h00);
    test_header_err(8'h11);
    test_full_gaps();
    test_rst_midload();
    test_rst_priority();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
